// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit pipelined CPU: widths and ALU opcodes.
package cpu8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_W  = 3;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOT   = 4'd5,
    ALU_SHL   = 4'd6,
    ALU_SHR   = 4'd7,
    ALU_PASSB = 4'd8
  } alu_op_e;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU; the 9th bit of the internal result is the carry/borrow.
module alu8
  import cpu8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              c
);

  logic [DATA_W:0] w_res;

  // Opcode decode; unused opcodes give zero result and zero carry
  always_comb begin
    w_res = '0;
    case (op)
      ALU_ADD:   w_res = {1'b0, a} + {1'b0, b};
      ALU_SUB:   w_res = {1'b0, a} - {1'b0, b};
      ALU_AND:   w_res = {1'b0, a & b};
      ALU_OR:    w_res = {1'b0, a | b};
      ALU_XOR:   w_res = {1'b0, a ^ b};
      ALU_NOT:   w_res = {1'b0, ~a};
      ALU_SHL:   w_res = {a, 1'b0};
      ALU_SHR:   w_res = {a[0], 1'b0, a[DATA_W-1:1]};
      ALU_PASSB: w_res = {1'b0, b};
      default:   w_res = '0;
    endcase
  end

  assign y = w_res[DATA_W-1:0];
  assign c = w_res[DATA_W];

endmodule

// File: rtl/ex_wb_stage.sv
// EX/WB stage: operand bypass, ALU/immediate select, WB register bank,
// status flags and retired-instruction counter.
module ex_wb_stage
  import cpu8_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_valid,
  input  logic [3:0]        EX_ALUop,
  input  logic              EX_regwrite,
  input  logic              EX_ImmLoad,
  input  logic [DATA_W-1:0] EX_regdata1,
  input  logic [DATA_W-1:0] EX_regdata2,
  input  logic [REG_W-1:0]  EX_rs1,
  input  logic [REG_W-1:0]  EX_rs2,
  input  logic [REG_W-1:0]  EX_writereg,
  input  logic [DATA_W-1:0] EX_ImmData,
  input  logic [DATA_W-1:0] EX_instr,
  input  logic              hold,
  input  logic              flush,
  output logic              WB_valid,
  output logic              WB_regwrite,
  output logic [REG_W-1:0]  WB_writereg,
  output logic [DATA_W-1:0] WB_result,
  output logic [DATA_W-1:0] WB_instr,
  output logic              flag_z,
  output logic              flag_c,
  output logic [CNT_W-1:0]  retired,
  output logic              ex_stall
);

  logic              r_valid;
  logic              r_regwrite;
  logic [REG_W-1:0]  r_writereg;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_instr;
  logic              r_z;
  logic              r_c;
  logic [CNT_W-1:0]  r_retired;

  logic              w_wb_we;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_alu_c;
  logic [DATA_W-1:0] w_res;
  logic              w_cy;

  assign w_wb_we = r_valid & r_regwrite;

  // Same-cycle bypass of the WB write into both EX operands
  always_comb begin
    w_opa = EX_regdata1;
    w_opb = EX_regdata2;
    if (w_wb_we && (r_writereg == EX_rs1)) w_opa = r_result;
    if (w_wb_we && (r_writereg == EX_rs2)) w_opb = r_result;
  end

  alu8 u_alu (
    .a  (w_opa),
    .b  (w_opb),
    .op (EX_ALUop),
    .y  (w_alu_y),
    .c  (w_alu_c)
  );

  // Immediate load overrides the ALU result and clears carry
  always_comb begin
    w_res = w_alu_y;
    w_cy  = w_alu_c;
    if (EX_ImmLoad) begin
      w_res = EX_ImmData;
      w_cy  = 1'b0;
    end
  end

  // WB register bank: reset > flush > hold > advance
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_writereg <= '0;
      r_result   <= '0;
      r_instr    <= '0;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
      r_retired  <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (!hold) begin
      r_valid    <= EX_valid;
      r_regwrite <= EX_regwrite;
      r_writereg <= EX_writereg;
      r_result   <= w_res;
      r_instr    <= EX_instr;
      if (EX_valid) begin
        r_retired <= r_retired + CNT_W'(1);
        r_z       <= (w_res == '0);
        r_c       <= w_cy;
      end
    end
  end

  assign WB_valid    = r_valid;
  assign WB_regwrite = w_wb_we;
  assign WB_writereg = r_writereg;
  assign WB_result   = r_result;
  assign WB_instr    = r_instr;
  assign flag_z      = r_z;
  assign flag_c      = r_c;
  assign retired     = r_retired;
  assign ex_stall    = hold;

endmodule
